// File: rtl/counter_game_pkg.sv
// Shared types and encodings for the counter-game controller slice.
// Holds the FSM states, counting modes, winner codes and run-length width.
package counter_game_pkg;

   localparam int RUN_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_LOAD   = 2'b01,
      ST_RUN    = 2'b10,
      ST_REPORT = 2'b11
   } state_e;

   typedef enum logic [1:0] {
      MODE_UP1 = 2'b00,
      MODE_UP2 = 2'b01,
      MODE_DN1 = 2'b10,
      MODE_DN2 = 2'b11
   } mode_e;

   localparam logic [1:0] WHO_NONE = 2'b00;
   localparam logic [1:0] WHO_LOSE = 2'b01;
   localparam logic [1:0] WHO_WIN  = 2'b10;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? 8'hFF : v + 8'd1;
   endfunction

endpackage

// File: rtl/counter_game_ctrl_if.sv
// Host-side command and result channels of the counter-game controller.
// The host is the master; the controller is the slave.
interface counter_game_ctrl_if;
   import counter_game_pkg::*;

   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_mode;
   logic             cmd_init;
   logic [3:0]       cmd_value;
   logic [RUN_W-1:0] cmd_cycles;

   logic             res_valid;
   logic             res_ready;
   logic [1:0]       res_who;
   logic [7:0]       res_cycle;

   modport master (
      output cmd_valid, cmd_mode, cmd_init, cmd_value, cmd_cycles, res_ready,
      input  cmd_ready, res_valid, res_who, res_cycle
   );

   modport slave (
      input  cmd_valid, cmd_mode, cmd_init, cmd_value, cmd_cycles, res_ready,
      output cmd_ready, res_valid, res_who, res_cycle
   );

endinterface

// File: rtl/counter_game_ctrl_sat_counter8.sv
// 8-bit tally counter that saturates at 255; synchronous clear wins over increment.
module sat_counter8
   import counter_game_pkg::*;
(
   input  logic       clk,
   input  logic       clr_i,
   input  logic       inc_i,
   output logic [7:0] cnt_o
);

   logic [7:0] cnt_q;

   // Tally register with clear priority.
   always_ff @(posedge clk) begin
      if (clr_i) begin
         cnt_q <= 8'd0;
      end else if (inc_i) begin
         cnt_q <= sat_inc8(cnt_q);
      end else begin
         cnt_q <= cnt_q;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/counter_game_ctrl.sv
// Sequences one counting game per host command: optional load, a bounded run,
// and a result report whose handshake updates the win/lose tallies.
module counter_game_ctrl
   import counter_game_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   counter_game_ctrl_if.slave  bus,
   output logic [1:0]          ctr_control,
   output logic                ctr_init,
   output logic [3:0]          ctr_initial_value,
   input  logic                ctr_gameover,
   input  logic [1:0]          ctr_who,
   output logic [7:0]          win_games,
   output logic [7:0]          lose_games,
   output logic                stray,
   output logic                busy
);

   state_e           state_q;
   logic             cmd_ready_q;
   logic             busy_q;
   logic [1:0]       mode_q;
   logic [RUN_W-1:0] rem_q;
   logic [1:0]       ctr_control_q;
   logic             ctr_init_q;
   logic [3:0]       ctr_initial_value_q;
   logic             res_valid_q;
   logic [1:0]       res_who_q;
   logic [7:0]       res_cycle_q;
   logic             stray_q;
   logic             report_done_d;
   logic             win_inc_d;
   logic             lose_inc_d;

   // Tally increments happen only on the result handshake.
   always_comb begin
      report_done_d = 1'b0;
      win_inc_d     = 1'b0;
      lose_inc_d    = 1'b0;
      if ((state_q == ST_REPORT) && bus.res_ready) begin
         report_done_d = 1'b1;
         win_inc_d     = (res_who_q == WHO_WIN);
         lose_inc_d    = (res_who_q == WHO_LOSE);
      end else begin
         report_done_d = 1'b0;
      end
   end

   // Controller FSM with all outputs registered.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q             <= ST_IDLE;
         cmd_ready_q         <= 1'b0;
         busy_q              <= 1'b0;
         mode_q              <= 2'b00;
         rem_q               <= '0;
         ctr_control_q       <= 2'b00;
         ctr_init_q          <= 1'b0;
         ctr_initial_value_q <= 4'd0;
         res_valid_q         <= 1'b0;
         res_who_q           <= 2'b00;
         res_cycle_q         <= 8'd0;
         stray_q             <= 1'b0;
      end else begin
         // A gameover outside RUN is only recorded, never acted on.
         if (ctr_gameover && (state_q != ST_RUN)) begin
            stray_q <= 1'b1;
         end
         case (state_q)
            ST_IDLE: begin
               cmd_ready_q <= 1'b1;
               busy_q      <= 1'b0;
               if (bus.cmd_valid && cmd_ready_q) begin
                  mode_q      <= bus.cmd_mode;
                  rem_q       <= bus.cmd_cycles;
                  cmd_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
                  if (bus.cmd_init) begin
                     state_q             <= ST_LOAD;
                     ctr_init_q          <= 1'b1;
                     ctr_initial_value_q <= bus.cmd_value;
                  end else begin
                     state_q       <= ST_RUN;
                     ctr_control_q <= bus.cmd_mode;
                     res_cycle_q   <= 8'd1;
                  end
               end
            end
            ST_LOAD: begin
               state_q       <= ST_RUN;
               ctr_init_q    <= 1'b0;
               ctr_control_q <= mode_q;
               res_cycle_q   <= 8'd1;
            end
            ST_RUN: begin
               if (ctr_gameover) begin
                  state_q     <= ST_REPORT;
                  res_who_q   <= ctr_who;
                  res_valid_q <= 1'b1;
               end else if (rem_q == 8'd1) begin
                  state_q     <= ST_IDLE;
                  cmd_ready_q <= 1'b1;
                  busy_q      <= 1'b0;
               end else begin
                  // A loaded 0 wraps to 255 here, which gives the 256-cycle run.
                  rem_q       <= rem_q - 8'd1;
                  res_cycle_q <= sat_inc8(res_cycle_q);
               end
            end
            ST_REPORT: begin
               if (report_done_d) begin
                  state_q     <= ST_IDLE;
                  res_valid_q <= 1'b0;
                  cmd_ready_q <= 1'b1;
                  busy_q      <= 1'b0;
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               cmd_ready_q <= 1'b0;
               busy_q      <= 1'b0;
               res_valid_q <= 1'b0;
               ctr_init_q  <= 1'b0;
            end
         endcase
      end
   end

   sat_counter8 u_win_tally (
      .clk   (clk),
      .clr_i (reset),
      .inc_i (win_inc_d),
      .cnt_o (win_games)
   );

   sat_counter8 u_lose_tally (
      .clk   (clk),
      .clr_i (reset),
      .inc_i (lose_inc_d),
      .cnt_o (lose_games)
   );

   assign bus.cmd_ready     = cmd_ready_q;
   assign bus.res_valid     = res_valid_q;
   assign bus.res_who       = res_who_q;
   assign bus.res_cycle     = res_cycle_q;
   assign ctr_control       = ctr_control_q;
   assign ctr_init          = ctr_init_q;
   assign ctr_initial_value = ctr_initial_value_q;
   assign stray             = stray_q;
   assign busy              = busy_q;

endmodule

// File: tb/tb_counter_game_ctrl.sv
// Scoreboard bench for counter_game_ctrl: expected results are queued when a
// gameover is injected and compared when res_valid appears.
module tb_counter_game_ctrl;

   typedef struct {
      logic [1:0] who;
      logic [7:0] cycle;
   } exp_res_t;

   logic       clk;
   logic       reset;
   logic [1:0] ctr_control;
   logic       ctr_init;
   logic [3:0] ctr_initial_value;
   logic       ctr_gameover;
   logic [1:0] ctr_who;
   logic [7:0] win_games;
   logic [7:0] lose_games;
   logic       stray;
   logic       busy;

   int         checks;
   int         failures;
   int         win_m;
   int         lose_m;
   exp_res_t   sb_q[$];

   counter_game_ctrl_if bus ();

   counter_game_ctrl dut (
      .clk               (clk),
      .reset             (reset),
      .bus               (bus.slave),
      .ctr_control       (ctr_control),
      .ctr_init          (ctr_init),
      .ctr_initial_value (ctr_initial_value),
      .ctr_gameover      (ctr_gameover),
      .ctr_who           (ctr_who),
      .win_games         (win_games),
      .lose_games        (lose_games),
      .stray             (stray),
      .busy              (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_values();
      chk("rst_cmd_ready", bus.cmd_ready, 0);
      chk("rst_ctr_control", ctr_control, 0);
      chk("rst_ctr_init", ctr_init, 0);
      chk("rst_ctr_value", ctr_initial_value, 0);
      chk("rst_res_valid", bus.res_valid, 0);
      chk("rst_res_who", bus.res_who, 0);
      chk("rst_res_cycle", bus.res_cycle, 0);
      chk("rst_win", win_games, 0);
      chk("rst_lose", lose_games, 0);
      chk("rst_stray", stray, 0);
      chk("rst_busy", busy, 0);
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      win_m  = 0;
      lose_m = 0;
      check_reset_values();
      tick();
      chk("rst_ready_after", bus.cmd_ready, 1);
   endtask

   task automatic wait_ready();
      for (int i = 0; i < 20; i++) begin
         if (bus.cmd_ready === 1'b1) break;
         tick();
      end
      chk("cmd_ready_wait", bus.cmd_ready, 1);
   endtask

   // go_at = RUN cycle in which gameover is raised (0 = never).
   task automatic run_game(input logic init, input logic [3:0] value, input logic [1:0] mode,
                           input logic [7:0] cycles, input int go_at, input logic [1:0] who,
                           input int ready_delay, input logic abort_report);
      int       run_len;
      exp_res_t e;
      wait_ready();
      bus.cmd_valid  = 1'b1;
      bus.cmd_init   = init;
      bus.cmd_value  = value;
      bus.cmd_mode   = mode;
      bus.cmd_cycles = cycles;
      tick();
      bus.cmd_valid  = 1'b0;
      bus.cmd_value  = 4'd0;
      bus.cmd_mode   = ~mode;
      chk("busy_accept", busy, 1);
      chk("ready_drop", bus.cmd_ready, 0);
      if (init) begin
         chk("load_init", ctr_init, 1);
         chk("load_value", ctr_initial_value, value);
         tick();
      end
      run_len = (cycles == 8'd0) ? 256 : int'(cycles);
      for (int k = 1; k <= run_len; k++) begin
         chk("run_init_low", ctr_init, 0);
         chk("run_control", ctr_control, mode);
         chk("run_cycle", bus.res_cycle, (k > 255) ? 255 : k);
         chk("run_busy", busy, 1);
         if (k == go_at) begin
            ctr_gameover = 1'b1;
            ctr_who      = who;
            e.who   = who;
            e.cycle = (k > 255) ? 8'd255 : 8'(k);
            sb_q.push_back(e);
            tick();
            ctr_gameover = 1'b0;
            ctr_who      = 2'b00;
            break;
         end
         tick();
      end
      if (go_at == 0 || go_at > run_len) begin
         chk("expire_ready", bus.cmd_ready, 1);
         chk("expire_busy", busy, 0);
         chk("expire_no_res", bus.res_valid, 0);
         chk("expire_ctl_hold", ctr_control, mode);
      end else begin
         chk("res_valid_set", bus.res_valid, 1);
         chk("report_not_ready", bus.cmd_ready, 0);
         if (sb_q.size() == 0) begin
            chk("sb_nonempty", 0, 1);
         end else begin
            e = sb_q.pop_front();
            chk("res_who", bus.res_who, e.who);
            chk("res_cycle", bus.res_cycle, e.cycle);
            if (!abort_report) begin
               bus.res_ready = 1'b0;
               for (int d = 0; d < ready_delay; d++) begin
                  tick();
                  chk("hold_valid", bus.res_valid, 1);
                  chk("hold_who", bus.res_who, e.who);
                  chk("hold_cycle", bus.res_cycle, e.cycle);
               end
               bus.res_ready = 1'b1;
               tick();
               bus.res_ready = 1'b0;
               if (e.who == 2'b10 && win_m < 255) win_m++;
               if (e.who == 2'b01 && lose_m < 255) lose_m++;
               chk("post_valid_drop", bus.res_valid, 0);
               chk("post_ready", bus.cmd_ready, 1);
               chk("post_busy", busy, 0);
               chk("win_tally", win_games, win_m);
               chk("lose_tally", lose_games, lose_m);
            end
         end
      end
   endtask

   initial begin
      checks        = 0;
      failures      = 0;
      win_m         = 0;
      lose_m        = 0;
      reset         = 1'b1;
      ctr_gameover  = 1'b0;
      ctr_who       = 2'b00;
      bus.cmd_valid = 1'b0;
      bus.cmd_mode  = 2'b00;
      bus.cmd_init  = 1'b0;
      bus.cmd_value = 4'd0;
      bus.cmd_cycles = 8'd0;
      bus.res_ready = 1'b0;
      tick();
      tick();
      apply_reset();

      // Load then a 3-cycle up1 run.
      run_game(1'b1, 4'd5, 2'b00, 8'd3, 0, 2'b00, 0, 1'b0);
      // Win at RUN cycle 4 of 10, result held for 3 cycles.
      run_game(1'b0, 4'd0, 2'b01, 8'd10, 4, 2'b10, 3, 1'b0);
      // Gameover on the final RUN cycle beats expiry.
      run_game(1'b0, 4'd0, 2'b10, 8'd6, 6, 2'b01, 0, 1'b0);
      // NONE result leaves tallies alone.
      run_game(1'b1, 4'd15, 2'b11, 8'd2, 2, 2'b00, 1, 1'b0);
      // 256-cycle runs: expiry, then gameover at cycle 256.
      run_game(1'b0, 4'd0, 2'b11, 8'd0, 0, 2'b00, 0, 1'b0);
      run_game(1'b1, 4'd9, 2'b00, 8'd0, 256, 2'b10, 1, 1'b0);

      // Stray gameover in IDLE.
      ctr_gameover = 1'b1;
      ctr_who      = 2'b10;
      tick();
      ctr_gameover = 1'b0;
      ctr_who      = 2'b00;
      tick();
      chk("stray_set", stray, 1);
      chk("stray_win", win_games, win_m);
      chk("stray_lose", lose_games, lose_m);
      chk("stray_idle", busy, 0);

      // Saturate the win tally.
      for (int g = 0; g < 256; g++) begin
         run_game(1'b0, 4'd0, 2'b00, 8'd1, 1, 2'b10, 0, 1'b0);
      end
      chk("win_saturated", win_games, 255);
      chk("stray_sticky", stray, 1);

      // Reset in RUN cycle 2.
      wait_ready();
      bus.cmd_valid  = 1'b1;
      bus.cmd_init   = 1'b0;
      bus.cmd_mode   = 2'b01;
      bus.cmd_cycles = 8'd10;
      tick();
      bus.cmd_valid = 1'b0;
      tick();
      chk("abort_run_cycle", bus.res_cycle, 2);
      apply_reset();

      // Build a tally, then reset with a pending result.
      run_game(1'b0, 4'd0, 2'b00, 8'd5, 2, 2'b10, 0, 1'b0);
      chk("pre_abort_win", win_games, 1);
      run_game(1'b0, 4'd0, 2'b00, 8'd5, 3, 2'b01, 0, 1'b1);
      chk("abort_pending", bus.res_valid, 1);
      bus.res_ready = 1'b1;
      apply_reset();
      bus.res_ready = 1'b0;
      tick();
      chk("abort_lose", lose_games, 0);
      chk("abort_sb_empty", sb_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/counter_game_ctrl.md
COUNTER_GAME_CTRL -- requirements
Module: counter_game_ctrl

Interface
REQ-001 SHALL have port: clk  in  1  rising-edge clock for all state.
REQ-002 SHALL have port: reset  in  1  synchronous, active-high reset; clock is clk.
REQ-003 SHALL have port: cmd_valid  in  1  host command present.
REQ-004 SHALL have port: cmd_ready  out  1  controller accepts a command.
REQ-005 SHALL have port: cmd_mode  in  2  counting mode: 00 up1, 01 up2, 10 down1, 11 down2.
REQ-006 SHALL have port: cmd_init  in  1  load counter before run.
REQ-007 SHALL have port: cmd_value  in  4  initial value for the load.
REQ-008 SHALL have port: cmd_cycles  in  8  run length in clocks; 0 means 256.
REQ-009 SHALL have ports: ctr_control  out  2, ctr_init  out  1, ctr_initial_value  out  4; these drive the counter.
REQ-010 SHALL have ports: ctr_gameover  in  1, ctr_who  in  2; these are sampled from the counter.
REQ-011 SHALL have ports: res_valid  out  1, res_ready  in  1, res_who  out  2, res_cycle  out  8; these form the result channel.
REQ-012 SHALL have ports: win_games  out  8, lose_games  out  8, stray  out  1, busy  out  1.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, RUN, REPORT.
REQ-014 SHALL assert cmd_ready only in IDLE; a command is accepted on the clk edge where cmd_valid and cmd_ready are both high.
REQ-015 SHALL latch the command fields on accept and hold them until the command completes.
REQ-016 On accept, SHALL go IDLE->LOAD if cmd_init=1, otherwise IDLE->RUN.
REQ-017 In LOAD, SHALL drive ctr_init=1 with ctr_initial_value equal to the latched value for exactly one cycle, then go LOAD->RUN.
REQ-018 SHALL drive ctr_init=0 in every state other than LOAD.
REQ-019 In RUN, SHALL drive ctr_control equal to the latched mode.
REQ-020 In RUN, SHALL decrement an 8-bit remaining count each cycle.
REQ-021 In RUN, SHALL increment res_cycle from 1 each cycle; res_cycle saturates at 255.
REQ-022 SHALL go RUN->IDLE on the cycle where the remaining count is 1 and ctr_gameover=0; cmd_cycles=N therefore yields exactly N RUN cycles, and 0 yields 256.
REQ-023 SHALL go RUN->REPORT when ctr_gameover=1 in RUN and capture ctr_who into res_who; gameover takes priority over expiry in the same cycle.
REQ-024 In REPORT, SHALL hold res_valid=1 with res_who and res_cycle stable until res_ready=1, then go REPORT->IDLE; res_valid SHALL drop in the cycle after the handshake.
REQ-025 On the REPORT handshake, SHALL increment win_games if res_who=10 and lose_games if res_who=01, saturating at 255; other codes SHALL leave both tallies unchanged.
REQ-026 When ctr_gameover=1 outside RUN, SHALL set sticky stray=1 and take no other action; stray is cleared only by reset.
REQ-027 SHALL hold ctr_control at its last value outside RUN.
REQ-028 SHALL drive busy=1 in every state except IDLE.

Reset
REQ-029 On reset, SHALL enter IDLE.
REQ-030 On reset, SHALL clear cmd_ready to 0, then assert it in the first cycle after reset deasserts.
REQ-031 On reset, SHALL clear ctr_control=00, ctr_init=0, ctr_initial_value=0.
REQ-032 On reset, SHALL clear res_valid=0, res_who=00, res_cycle=0.
REQ-033 On reset, SHALL clear win_games=0, lose_games=0, stray=0, busy=0.
REQ-034 Reset in any state, including mid-RUN or with a pending result, SHALL abort the command and discard the result without updating the tallies.

Structure
REQ-035 SHALL place the state enum, the mode encodings (UP1/UP2/DN1/DN2), the WHO encodings (NONE=00, LOSE=01, WIN=10), and the run-length width in a shared package, counter_game_pkg.
REQ-036 SHALL instantiate sub-module sat_counter8 (8-bit saturating counter with increment enable and synchronous clear) twice, once for win_games and once for lose_games.

Verification
REQ-037 Scenario: cmd_init=1, cmd_value=5, cmd_mode=00, cmd_cycles=3 -> ctr_init high for 1 cycle with ctr_initial_value=5, ctr_control=00 for 3 cycles, then cmd_ready=1.
REQ-038 Scenario: cmd_cycles=10 and ctr_gameover=1 with ctr_who=10 in RUN cycle 4 -> res_valid=1, res_who=10, res_cycle=4; with res_ready delayed 3 cycles, outputs stay stable; after the handshake win_games=1.
REQ-039 Scenario: ctr_gameover=1 in the final RUN cycle with ctr_who=01 -> REPORT is entered rather than IDLE, and lose_games increments after the handshake.
REQ-040 Scenario: cmd_cycles=0 -> exactly 256 RUN cycles, and res_cycle reads 255 if gameover occurs at cycle 256.
REQ-041 Scenario: 256 winning games -> win_games saturates at 255; ctr_gameover pulsed while in IDLE -> stray=1 and tallies unchanged.
REQ-042 Scenario: reset asserted in RUN cycle 2 and again with res_valid=1 -> IDLE next cycle, all outputs at reset values, tallies unchanged by the aborted result.
